// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Consumers: pipeline_control_unit, perf_counter_sat, pipeline stage registers.
package pipeline_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } ctrl_state_e;

  // Bubble loaded by IF/ID on flush (addi x0, x0, 0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Per-cycle cause, lower value wins
  localparam logic [2:0] PRIO_FREEZE       = 3'd0;
  localparam logic [2:0] PRIO_REDIRECT     = 3'd1;
  localparam logic [2:0] PRIO_LOAD_USE     = 3'd2;
  localparam logic [2:0] PRIO_FETCH_BUBBLE = 3'd3;
  localparam logic [2:0] PRIO_NORMAL       = 3'd4;

  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } ctrl_out_t;

endpackage

// File: rtl/perf_counter_sat.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module perf_counter_sat #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush/redirect controller for the 5-stage pipeline with wrong-path fetch tracking.
// Define PIPELINE_PERF_COUNTERS_EN to build the saturating event counters; otherwise they read 0.
module pipeline_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_use_hazard,
  input  logic                 ex_branch_taken,
  input  logic [XLEN-1:0]      ex_branch_target,
  input  logic                 dmem_busy,
  input  logic                 imem_ready,
  output logic                 pc_en,
  output logic                 pc_redirect,
  output logic [XLEN-1:0]      pc_redirect_target,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_en,
  output logic                 idex_flush,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic [CNT_WIDTH-1:0] cnt_load_stall,
  output logic [CNT_WIDTH-1:0] cnt_freeze,
  output logic [CNT_WIDTH-1:0] cnt_redirect
);

  ctrl_state_e     state_q;
  ctrl_state_e     state_d;
  logic [2:0]      cause_c;
  ctrl_out_t       ctl_c;
  logic [XLEN-1:0] target_c;

  // Highest-priority event this cycle
  always_comb begin
    cause_c = PRIO_NORMAL;
    if (dmem_busy) begin
      cause_c = PRIO_FREEZE;
    end else if (ex_branch_taken) begin
      cause_c = PRIO_REDIRECT;
    end else if (load_use_hazard) begin
      cause_c = PRIO_LOAD_USE;
    end else if (!imem_ready || (state_q == ST_DRAIN)) begin
      cause_c = PRIO_FETCH_BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and zero-latency control outputs
  always_comb begin
    state_d  = state_q;
    ctl_c    = '0;
    target_c = '0;
    if (rst) begin
      state_d          = ST_RUN;
      ctl_c.ifid_flush = 1'b1;
      ctl_c.idex_flush = 1'b1;
    end else begin
      case (cause_c)
        PRIO_FREEZE: begin
          // A stale fetch returning while frozen is still consumed
          if ((state_q == ST_DRAIN) && imem_ready) begin
            state_d = ST_RUN;
          end
        end
        PRIO_REDIRECT: begin
          ctl_c       = '1;
          target_c    = ex_branch_target;
          state_d     = imem_ready ? ST_RUN : ST_DRAIN;
        end
        PRIO_LOAD_USE: begin
          ctl_c.idex_en    = 1'b1;
          ctl_c.idex_flush = 1'b1;
          ctl_c.exmem_en   = 1'b1;
          ctl_c.memwb_en   = 1'b1;
          // IF/ID is held, so a stale word arriving now is simply dropped
          if (imem_ready) begin
            state_d = ST_RUN;
          end
        end
        PRIO_FETCH_BUBBLE: begin
          ctl_c.ifid_en    = 1'b1;
          ctl_c.ifid_flush = 1'b1;
          ctl_c.idex_en    = 1'b1;
          ctl_c.exmem_en   = 1'b1;
          ctl_c.memwb_en   = 1'b1;
          if (imem_ready) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          ctl_c.pc_en    = 1'b1;
          ctl_c.ifid_en  = 1'b1;
          ctl_c.idex_en  = 1'b1;
          ctl_c.exmem_en = 1'b1;
          ctl_c.memwb_en = 1'b1;
        end
      endcase
    end
  end

  assign pc_en              = ctl_c.pc_en;
  assign pc_redirect        = ctl_c.pc_redirect;
  assign pc_redirect_target = target_c;
  assign ifid_en            = ctl_c.ifid_en;
  assign ifid_flush         = ctl_c.ifid_flush;
  assign idex_en            = ctl_c.idex_en;
  assign idex_flush         = ctl_c.idex_flush;
  assign exmem_en           = ctl_c.exmem_en;
  assign memwb_en           = ctl_c.memwb_en;

`ifdef PIPELINE_PERF_COUNTERS_EN
  logic inc_load_stall_c;
  logic inc_freeze_c;
  logic inc_redirect_c;

  assign inc_load_stall_c = (cause_c == PRIO_LOAD_USE);
  assign inc_freeze_c     = (cause_c == PRIO_FREEZE);
  assign inc_redirect_c   = (cause_c == PRIO_REDIRECT);

  perf_counter_sat #(.W(CNT_WIDTH)) u_cnt_load_stall (
    .clk     (clk),
    .rst     (rst),
    .en_i    (inc_load_stall_c),
    .count_o (cnt_load_stall)
  );

  perf_counter_sat #(.W(CNT_WIDTH)) u_cnt_freeze (
    .clk     (clk),
    .rst     (rst),
    .en_i    (inc_freeze_c),
    .count_o (cnt_freeze)
  );

  perf_counter_sat #(.W(CNT_WIDTH)) u_cnt_redirect (
    .clk     (clk),
    .rst     (rst),
    .en_i    (inc_redirect_c),
    .count_o (cnt_redirect)
  );
`else
  assign cnt_load_stall = '0;
  assign cnt_freeze     = '0;
  assign cnt_redirect   = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed-vector bench for pipeline_control_unit; counter expectations follow PIPELINE_PERF_COUNTERS_EN.
module tb_pipeline_control_unit;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CNT_WIDTH = 32;
`ifdef PIPELINE_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  localparam logic [7:0] C_RST    = 8'b0001_0100;
  localparam logic [7:0] C_RUN    = 8'b1010_1011;
  localparam logic [7:0] C_FREEZE = 8'b0000_0000;
  localparam logic [7:0] C_REDIR  = 8'b1111_1111;
  localparam logic [7:0] C_LU     = 8'b0000_1111;
  localparam logic [7:0] C_BUBBLE = 8'b0011_1011;

  logic                 clk;
  logic                 rst;
  logic                 load_use_hazard;
  logic                 ex_branch_taken;
  logic [XLEN-1:0]      ex_branch_target;
  logic                 dmem_busy;
  logic                 imem_ready;
  logic                 pc_en;
  logic                 pc_redirect;
  logic [XLEN-1:0]      pc_redirect_target;
  logic                 ifid_en;
  logic                 ifid_flush;
  logic                 idex_en;
  logic                 idex_flush;
  logic                 exmem_en;
  logic                 memwb_en;
  logic [CNT_WIDTH-1:0] cnt_load_stall;
  logic [CNT_WIDTH-1:0] cnt_freeze;
  logic [CNT_WIDTH-1:0] cnt_redirect;
  logic [7:0]           ctl;

  int unsigned n_vec;
  int unsigned n_err;

  pipeline_control_unit #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .load_use_hazard    (load_use_hazard),
    .ex_branch_taken    (ex_branch_taken),
    .ex_branch_target   (ex_branch_target),
    .dmem_busy          (dmem_busy),
    .imem_ready         (imem_ready),
    .pc_en              (pc_en),
    .pc_redirect        (pc_redirect),
    .pc_redirect_target (pc_redirect_target),
    .ifid_en            (ifid_en),
    .ifid_flush         (ifid_flush),
    .idex_en            (idex_en),
    .idex_flush         (idex_flush),
    .exmem_en           (exmem_en),
    .memwb_en           (memwb_en),
    .cnt_load_stall     (cnt_load_stall),
    .cnt_freeze         (cnt_freeze),
    .cnt_redirect       (cnt_redirect)
  );

  assign ctl = {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] cexp(input int unsigned n);
    return PERF ? 64'(n) : 64'd0;
  endfunction

  // Drive one cycle of inputs just after the rising edge, leave time to settle
  task automatic step(input logic r, input logic lu, input logic bt, input logic [XLEN-1:0] tgt,
                      input logic busy, input logic ir);
    @(posedge clk);
    #1;
    rst              = r;
    load_use_hazard  = lu;
    ex_branch_taken  = bt;
    ex_branch_target = tgt;
    dmem_busy        = busy;
    imem_ready       = ir;
    #2;
  endtask

  task automatic check_counters(input string tag, input int unsigned ls, input int unsigned fz,
                                input int unsigned rd);
    check_eq({tag, ".cnt_load_stall"}, 64'(cnt_load_stall), cexp(ls));
    check_eq({tag, ".cnt_freeze"},     64'(cnt_freeze),     cexp(fz));
    check_eq({tag, ".cnt_redirect"},   64'(cnt_redirect),   cexp(rd));
  endtask

  initial begin
    n_vec            = 0;
    n_err            = 0;
    rst              = 1'b1;
    load_use_hazard  = 1'b0;
    ex_branch_taken  = 1'b0;
    ex_branch_target = '0;
    dmem_busy        = 1'b0;
    imem_ready       = 1'b1;

    // Reset held with a freeze and branch pending
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1);
    check_eq("rst.ctl", 64'(ctl), 64'(C_RST));
    check_eq("rst.target", 64'(pc_redirect_target), 64'd0);
    check_counters("rst", 0, 0, 0);

    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("run0.ctl", 64'(ctl), 64'(C_RUN));
    check_counters("run0", 0, 0, 0);

    // Load-use stall for one cycle
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    check_eq("lu.ctl", 64'(ctl), 64'(C_LU));
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("lu_after.ctl", 64'(ctl), 64'(C_RUN));
    check_counters("lu_after", 1, 0, 0);

    // Redirect with fetch outstanding, then drain the stale word
    step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    check_eq("redir.ctl", 64'(ctl), 64'(C_REDIR));
    check_eq("redir.target", 64'(pc_redirect_target), 64'h100);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b1);
    check_eq("drain.ctl", 64'(ctl), 64'(C_BUBBLE));
    check_eq("drain.target", 64'(pc_redirect_target), 64'd0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("drain_done.ctl", 64'(ctl), 64'(C_RUN));
    check_counters("drain_done", 1, 0, 1);

    // Redirect beats a simultaneous load-use; imem_ready keeps state RUN
    step(1'b0, 1'b1, 1'b1, 32'h0000_0180, 1'b0, 1'b1);
    check_eq("redir_lu.ctl", 64'(ctl), 64'(C_REDIR));
    check_eq("redir_lu.target", 64'(pc_redirect_target), 64'h180);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("redir_lu_after.ctl", 64'(ctl), 64'(C_RUN));
    check_counters("redir_lu_after", 1, 0, 2);

    // Freeze for four cycles with a branch held in EX
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
      check_eq($sformatf("freeze%0d.ctl", i), 64'(ctl), 64'(C_FREEZE));
      check_eq($sformatf("freeze%0d.target", i), 64'(pc_redirect_target), 64'd0);
    end
    step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b1);
    check_eq("unfreeze.ctl", 64'(ctl), 64'(C_REDIR));
    check_eq("unfreeze.target", 64'(pc_redirect_target), 64'h200);
    check_counters("unfreeze", 1, 4, 2);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("unfreeze_after.ctl", 64'(ctl), 64'(C_RUN));
    check_counters("unfreeze_after", 1, 4, 3);

    // Stale fetch returning during a freeze clears DRAIN
    step(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
    check_eq("redir2.ctl", 64'(ctl), 64'(C_REDIR));
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    check_eq("drain_freeze.ctl", 64'(ctl), 64'(C_FREEZE));
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("drain_freeze_after.ctl", 64'(ctl), 64'(C_RUN));
    check_counters("drain_freeze_after", 1, 5, 4);

    // Plain fetch bubble in RUN
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_eq("bubble.ctl", 64'(ctl), 64'(C_BUBBLE));

    // Reset mid-DRAIN and mid-freeze
    step(1'b0, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 1'b0);
    check_eq("redir3.ctl", 64'(ctl), 64'(C_REDIR));
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("rst2.ctl", 64'(ctl), 64'(C_RST));
    check_counters("rst2", 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("post_rst.ctl", 64'(ctl), 64'(C_RUN));
    check_counters("post_rst", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
